// File: rtl/ov7670_dvp_emulator_if.sv
// DVP pixel bus between an OV7670-style camera (or its emulator) and the camera controller.
interface ov7670_dvp_emulator_if;
  logic       cam_pclk;
  logic       cam_vsync;
  logic       cam_href;
  logic [7:0] cam_data;

  modport master (output cam_pclk, cam_vsync, cam_href, cam_data);
  modport slave  (input  cam_pclk, cam_vsync, cam_href, cam_data);
endinterface

// File: rtl/ov7670_dvp_emulator.sv
// OV7670 sensor stand-in: drives RGB565 test frames (high byte first) on a DVP bus
// with OV7670-style vsync/href timing; everything advances on pclk falling edges.
module ov7670_dvp_emulator #(
  parameter int IMG_WIDTH   = 160,
  parameter int IMG_HEIGHT  = 120,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [1:0]                   pattern_sel,
  input  logic [15:0]                  solid_rgb565,
  ov7670_dvp_emulator_if.master        dvp,
  output logic                         frame_start,
  output logic                         frame_done,
  output logic [15:0]                  frame_cnt,
  output logic                         busy
);

  localparam int ACT_BYTES  = 2 * IMG_WIDTH;
  localparam int LINE_TICKS = ACT_BYTES + H_BLANK;
  localparam int MAX_LINES  = (IMG_HEIGHT > V_BACK)
                              ? ((IMG_HEIGHT > V_FRONT) ? ((IMG_HEIGHT > VSYNC_LINES) ? IMG_HEIGHT : VSYNC_LINES)
                                                        : ((V_FRONT > VSYNC_LINES) ? V_FRONT : VSYNC_LINES))
                              : ((V_BACK > V_FRONT) ? ((V_BACK > VSYNC_LINES) ? V_BACK : VSYNC_LINES)
                                                    : ((V_FRONT > VSYNC_LINES) ? V_FRONT : VSYNC_LINES));
  localparam int HW = (LINE_TICKS > 1) ? $clog2(LINE_TICKS) : 1;
  localparam int LW = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1;

  localparam logic [15:0] BAR_RGB [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                         16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  typedef enum logic [2:0] {
    S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_HBLANK, S_VFRONT
  } state_t;

  state_t          state, state_nxt;
  logic [HW-1:0]   h_cnt, h_nxt;
  logic [LW-1:0]   line_cnt, line_nxt, last_line;
  logic            pclk_q;
  logic [1:0]      pat_q;
  logic [15:0]     solid_q;
  logic            start_frame, end_frame, line_end, tick;
  logic [7:0]      x8, y8;
  logic [2:0]      bar;
  logic [15:0]     pixel;
  logic            unused_y;

  // pclk is a plain data output; a tick is the clk edge on which it falls.
  assign tick     = pclk_q;
  assign line_end = (h_cnt == HW'(LINE_TICKS - 1));

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_nxt   = state;
    h_nxt       = h_cnt;
    line_nxt    = line_cnt;
    start_frame = 1'b0;
    end_frame   = 1'b0;
    last_line   = '0;

    case (state)
      S_VSYNC: last_line = LW'(VSYNC_LINES - 1);
      S_VBACK: last_line = LW'(V_BACK - 1);
      default: last_line = LW'(V_FRONT - 1);
    endcase

    case (state)
      S_IDLE: begin
        if (enable) begin
          state_nxt   = S_VSYNC;
          start_frame = 1'b1;
        end
      end
      S_VSYNC, S_VBACK, S_VFRONT: begin
        h_nxt = line_end ? '0 : h_cnt + 1'b1;
        if (line_end) begin
          if (line_cnt == last_line) begin
            line_nxt = '0;
            case (state)
              S_VSYNC: state_nxt = S_VBACK;
              S_VBACK: state_nxt = S_ACTIVE;
              default: begin
                end_frame = 1'b1;
                if (enable) begin
                  state_nxt   = S_VSYNC;
                  start_frame = 1'b1;
                end else begin
                  state_nxt = S_IDLE;
                end
              end
            endcase
          end else begin
            line_nxt = line_cnt + 1'b1;
          end
        end
      end
      S_ACTIVE: begin
        h_nxt = h_cnt + 1'b1;
        if (h_cnt == HW'(ACT_BYTES - 1)) state_nxt = S_HBLANK;
      end
      S_HBLANK: begin
        h_nxt = line_end ? '0 : h_cnt + 1'b1;
        if (line_end) begin
          if (line_cnt == LW'(IMG_HEIGHT - 1)) begin
            line_nxt  = '0;
            state_nxt = S_VFRONT;
          end else begin
            line_nxt  = line_cnt + 1'b1;
            state_nxt = S_ACTIVE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pclk_q      <= 1'b0;
      state       <= S_IDLE;
      h_cnt       <= '0;
      line_cnt    <= '0;
      pat_q       <= '0;
      solid_q     <= '0;
      frame_cnt   <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
      pclk_q      <= ~pclk_q;
      frame_start <= tick & start_frame;
      frame_done  <= tick & end_frame;
      if (tick) begin
        state    <= state_nxt;
        h_cnt    <= h_nxt;
        line_cnt <= line_nxt;
        if (start_frame) begin
          pat_q   <= pattern_sel;
          solid_q <= solid_rgb565;
        end
        if (end_frame) frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  // Pixel generator: in ACTIVE, h_cnt is the byte index and line_cnt is y.
  always_comb begin
    x8  = 8'(h_cnt >> 1);
    y8  = 8'(line_cnt);
    bar = '0;
    for (int k = 1; k < 8; k++) begin
      if (int'(x8) * 8 >= k * IMG_WIDTH) bar = 3'(k);
    end
    case (pat_q)
      2'd0:    pixel = BAR_RGB[bar];
      2'd1:    pixel = solid_q;
      2'd2:    pixel = {x8[7:3], y8[6:1], x8[4:0]};
      default: pixel = (x8[3] ^ y8[3] ^ frame_cnt[0]) ? 16'hFFFF : 16'h0000;
    endcase
  end

  assign unused_y = ^{y8[7], y8[0]};

  assign dvp.cam_pclk  = pclk_q;
  assign dvp.cam_vsync = (state == S_VSYNC);
  assign dvp.cam_href  = (state == S_ACTIVE);
  assign dvp.cam_data  = (state == S_ACTIVE) ? (h_cnt[0] ? pixel[7:0] : pixel[15:8]) : 8'h00;
  assign busy          = (state != S_IDLE);

endmodule

// File: tb/tb_ov7670_dvp_emulator.sv
// Directed bench for ov7670_dvp_emulator using reduced frame geometry (40-tick lines, 19-line frames).
module tb_ov7670_dvp_emulator;

  localparam int W     = 16;
  localparam int H     = 12;
  localparam int HB    = 8;
  localparam int VS    = 2;
  localparam int VB    = 3;
  localparam int VF    = 2;
  localparam int LINE  = 2 * W + HB;
  localparam int FRAME = (VS + VB + H + VF) * LINE;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic [15:0] solid_rgb565;
  logic        frame_start, frame_done, busy;
  logic [15:0] frame_cnt;

  ov7670_dvp_emulator_if dvp ();

  ov7670_dvp_emulator #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .H_BLANK(HB),
    .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .pattern_sel(pattern_sel),
    .solid_rgb565(solid_rgb565), .dvp(dvp), .frame_start(frame_start),
    .frame_done(frame_done), .frame_cnt(frame_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int href_rises = 0;
  int nbytes = 0;
  int data_idle_viol = 0;
  int data_edge_viol = 0;
  logic [7:0] last_data = 8'h00;
  logic [7:0] fb [H][2*W];

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge dvp.cam_href) href_rises <= href_rises + 1;

  // Data must be 0 outside href and may only move on edges where pclk falls.
  always @(posedge clk) begin
    #1;
    if (!dvp.cam_href && dvp.cam_data != 8'h00) data_idle_viol++;
    if (dvp.cam_pclk === 1'b1 && dvp.cam_data !== last_data) data_edge_viol++;
    last_data = dvp.cam_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pclk"},  dvp.cam_pclk, 0);
    check({tag, "_vsync"}, dvp.cam_vsync, 0);
    check({tag, "_href"},  dvp.cam_href, 0);
    check({tag, "_data"},  dvp.cam_data, 0);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_fstart"}, frame_start, 0);
    check({tag, "_fdone"}, frame_done, 0);
    check({tag, "_fcnt"},  frame_cnt, 0);
  endtask

  function automatic logic sig_val(input int which);
    case (which)
      0:       return dvp.cam_vsync;
      1:       return dvp.cam_href;
      2:       return frame_start;
      default: return frame_done;
    endcase
  endfunction

  task automatic wait_sig(input int which, input logic val, input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(posedge clk); #1;
      if (sig_val(which) === val) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  // Capture one frame's active bytes until frame_done. When row chg_row is reached,
  // apply the next pattern/colour; at act_row, act 1 drops enable, act 2 returns early.
  task automatic capture(input int chg_row, input logic [1:0] np, input logic [15:0] ns,
                         input int act_row, input int act, output bit done_ok);
    int row = 0;
    int col = 0;
    done_ok = 1'b0;
    nbytes = 0;
    for (int n = 0; n < 4 * FRAME; n++) begin
      @(posedge clk); #1;
      if (dvp.cam_pclk === 1'b0 && dvp.cam_href === 1'b1) begin
        if (row < H) fb[row][col] = dvp.cam_data;
        nbytes++;
        col++;
        if (col == 2 * W) begin
          col = 0;
          row++;
        end
      end
      if (row == chg_row) begin
        pattern_sel  = np;
        solid_rgb565 = ns;
      end
      if (row == act_row && act == 1) enable = 1'b0;
      if (row == act_row && act == 2) return;
      if (frame_done === 1'b1) begin
        done_ok = 1'b1;
        return;
      end
    end
  endtask

  function automatic logic [15:0] pix(input int x, input int y);
    return {fb[y][2*x], fb[y][2*x+1]};
  endfunction

  function automatic int count_bad(input logic [15:0] exp);
    int bad = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        if (pix(x, y) !== exp) bad++;
    return bad;
  endfunction

  initial begin
    bit ok;
    int t0, r0, hi, lo;
    logic [7:0] lb [2*W];

    reset = 1'b1; enable = 1'b1; pattern_sel = 2'd0; solid_rgb565 = 16'h0000;
    #1 reset = 1'b0;
    #1 check_all_zero("reset");
    @(negedge clk); reset = 1'b1;

    // Frame 1: colour bars and frame/line timing.
    @(posedge clk); #1;
    check("pclk_first_edge", dvp.cam_pclk, 1);
    check("no_start_before_tick", frame_start, 0);
    @(posedge clk); #1;
    check("frame_start_tick1", frame_start, 1);
    check("vsync_rise", dvp.cam_vsync, 1);
    check("busy_rise", busy, 1);
    t0 = cyc;
    r0 = href_rises;
    @(posedge clk); #1;
    check("frame_start_width", frame_start, 0);
    wait_sig(0, 1'b0, 4 * FRAME, ok);
    check("vsync_fall_seen", ok, 1);
    check("vsync_ticks", (cyc - t0) / 2, VS * LINE);
    wait_sig(1, 1'b1, 4 * FRAME, ok);
    check("href_rise_seen", ok, 1);
    check("href_offset_ticks", (cyc - t0) / 2, (VS + VB) * LINE);
    hi = 0;
    for (int i = 0; i < 2 * W; i++) begin
      lb[i] = dvp.cam_data;
      if (dvp.cam_href === 1'b1) hi++;
      repeat (2) @(posedge clk);
      #1;
    end
    check("href_high_ticks", hi, 2 * W);
    lo = 0;
    while (dvp.cam_href !== 1'b1 && lo < 4 * LINE) begin
      lo++;
      repeat (2) @(posedge clk);
      #1;
    end
    check("href_low_ticks", lo, HB);
    check("bar_bytes_0_1",   {lb[0],  lb[1]},  16'hFFFF);
    check("bar_bytes_4_5",   {lb[4],  lb[5]},  16'hFFE0);
    check("bar_bytes_8_9",   {lb[8],  lb[9]},  16'h07FF);
    check("bar_bytes_20_21", {lb[20], lb[21]}, 16'hF800);
    check("bar_bytes_24_25", {lb[24], lb[25]}, 16'h001F);
    check("bar_bytes_30_31", {lb[30], lb[31]}, 16'h0000);
    pattern_sel = 2'd1; solid_rgb565 = 16'h1234;
    wait_sig(3, 1'b1, 4 * FRAME, ok);
    check("frame1_done_seen", ok, 1);
    check("frame1_ticks", (cyc - t0) / 2, FRAME);
    check("frame1_cnt", frame_cnt, 1);
    check("frame1_href_pulses", href_rises - r0, H);
    check("back_to_back_start", frame_start, 1);

    // Frame 2: solid 1234; colour changed mid-frame must not leak in.
    capture(3, 2'd1, 16'hABCD, -1, 0, ok);
    check("frame2_done_seen", ok, 1);
    check("frame2_bytes", nbytes, 2 * W * H);
    check("frame2_solid_1234", count_bad(16'h1234), 0);
    check("frame2_cnt", frame_cnt, 2);

    // Frame 3: solid ABCD, latched at this frame's start.
    capture(H, 2'd2, 16'hABCD, -1, 0, ok);
    check("frame3_done_seen", ok, 1);
    check("frame3_solid_abcd", count_bad(16'hABCD), 0);

    // Frame 4: gradient.
    capture(H, 2'd3, 16'hABCD, -1, 0, ok);
    check("frame4_done_seen", ok, 1);
    check("grad_0_0",  pix(0, 0),   16'h0000);
    check("grad_9_5",  pix(9, 5),   16'h0849);
    check("grad_15_11", pix(15, 11), 16'h08AF);
    check("frame4_cnt", frame_cnt, 4);

    // Frames 5 and 6: checker; frame_cnt is 4 then 5 while they run.
    capture(-1, 2'd3, 16'hABCD, -1, 0, ok);
    check("frame5_done_seen", ok, 1);
    check("chk_even_0_0", pix(0, 0), 16'h0000);
    check("chk_even_8_0", pix(8, 0), 16'hFFFF);
    check("chk_even_0_8", pix(0, 8), 16'hFFFF);
    check("chk_even_8_8", pix(8, 8), 16'h0000);
    capture(-1, 2'd3, 16'hABCD, 6, 1, ok);
    check("frame6_done_seen", ok, 1);
    check("chk_odd_0_0", pix(0, 0), 16'hFFFF);
    check("chk_odd_8_0", pix(8, 0), 16'h0000);
    check("frame6_bytes", nbytes, 2 * W * H);

    // enable was dropped mid-frame 6: frame completes, then IDLE.
    check("idle_cnt", frame_cnt, 6);
    check("idle_no_start", frame_start, 0);
    check("idle_busy", busy, 0);
    check("idle_vsync", dvp.cam_vsync, 0);
    check("idle_href", dvp.cam_href, 0);
    check("idle_data", dvp.cam_data, 0);
    wait_sig(0, 1'b1, 4 * LINE, ok);
    check("idle_no_vsync", ok, 0);
    check("idle_busy_stays", busy, 0);

    // Frame 7 is aborted by reset after row 5.
    enable = 1'b1;
    wait_sig(2, 1'b1, 8, ok);
    check("restart_from_idle", ok, 1);
    check("restart_cnt_hold", frame_cnt, 6);
    capture(-1, 2'd3, 16'hABCD, 6, 2, ok);
    check("abort_before_done", ok, 0);
    check("busy_before_abort", busy, 1);
    reset = 1'b0;
    #1 check_all_zero("abort");
    @(posedge clk); #1;
    check("abort_pclk_held", dvp.cam_pclk, 0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("abort_pclk_first", dvp.cam_pclk, 1);
    check("abort_no_done_1", frame_done, 0);
    @(posedge clk); #1;
    check("abort_fresh_start", frame_start, 1);
    check("abort_no_done_2", frame_done, 0);
    check("abort_cnt_zero", frame_cnt, 0);
    t0 = cyc;
    wait_sig(3, 1'b1, 4 * FRAME, ok);
    check("after_abort_done_seen", ok, 1);
    check("after_abort_ticks", (cyc - t0) / 2, FRAME);
    check("after_abort_cnt", frame_cnt, 1);

    check("data_zero_outside_href", data_idle_viol, 0);
    check("data_moves_on_pclk_fall", data_edge_viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ov7670_dvp_emulator.md
Name: ov7670_dvp_emulator

Overview:
Synthesizable OV7670 sensor stand-in: the transmit side of the camera DVP pixel interface (pclk/vsync/href/data[7:0]).
Generates RGB565 frames, high byte first, with OV7670-style frame/line timing and selectable test patterns.
Drives the camera-controller input pins in simulation and on-board loopback, so the frame buffer and VGA path can be brought up without a sensor.

Parameters:
IMG_WIDTH, 160, active pixels per line (2 bytes each)
IMG_HEIGHT, 120, active lines per frame
H_BLANK, 144, pclk periods with href low after each active line
VSYNC_LINES, 3, line periods with vsync high
V_BACK, 17, blank line periods after vsync, before first active line
V_FRONT, 10, blank line periods after last active line

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
enable  in  1  start frames; sampled only in IDLE and at frame end
pattern_sel  in  2  0 color bars, 1 solid, 2 gradient, 3 checker
solid_rgb565  in  16  colour for pattern 1
cam_pclk  out  1  emulated pixel clock, clk/2
cam_vsync  out  1  frame sync, active high
cam_href  out  1  line valid, active high
cam_data  out  8  pixel byte
frame_start  out  1  one-clk pulse on vsync rise
frame_done  out  1  one-clk pulse at end of V_FRONT
frame_cnt  out  16  completed frames, wraps at 0xFFFF->0
busy  out  1  high from vsync rise to frame_done

Behaviour:
- Reset (reset=0, async): all outputs 0; FSM enters IDLE; all counters cleared. Reset mid-frame aborts immediately. No frame_done and no frame_cnt increment for the aborted frame.
- cam_pclk: register toggles every clk after reset release, first 1 on the first clk edge.
- Tick definition: "tick" = a clk edge where cam_pclk is 1 before the edge.
- Update timing: vsync, href, data, FSM and counters update only on ticks, i.e. on pclk falling edges. Values are therefore stable for one full clk before the pclk rise, where the receiver samples.
- FSM states: IDLE -> VSYNC -> VBACK -> ACTIVE <-> HBLANK -> VFRONT -> (VSYNC | IDLE).
  - IDLE: all outputs low. On a tick with enable=1, go to VSYNC.
  - Entry to VSYNC: latch pattern_sel and solid_rgb565; these latched values are held for the whole frame. Drive vsync=1 and busy=1. frame_start pulses for exactly 1 clk.
  - Line period = 2*IMG_WIDTH + H_BLANK ticks, used by VSYNC, VBACK and VFRONT.
  - VSYNC: VSYNC_LINES line periods, then VBACK with vsync=0.
  - VBACK: V_BACK line periods, href=0, then ACTIVE.
  - ACTIVE: href=1 for exactly 2*IMG_WIDTH ticks. Even byte index = pixel[15:8], odd = pixel[7:0]. x increments after each low byte.
  - HBLANK: H_BLANK ticks, href=0, data=0. y increments at HBLANK exit. After line IMG_HEIGHT-1, go to VFRONT; otherwise back to ACTIVE.
  - VFRONT: V_FRONT line periods, then frame_done pulses for 1 clk and frame_cnt increments.
  - After VFRONT: if enable=1, go directly to VSYNC with no gap. Otherwise go to IDLE and drop busy.
- enable deasserted mid-frame: current frame completes in full.
- cam_data when href=0: 0x00.
- Defaults: 464 ticks per line, 150 lines per frame, 69600 ticks = 139200 clk per frame.
- Patterns (x 0..IMG_WIDTH-1, y 0..IMG_HEIGHT-1):
  - 0 colour bars: 8 bars, each IMG_WIDTH/8 px wide, in order FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000. Bar index = x*8/IMG_WIDTH, integer.
  - 1 solid: latched solid_rgb565.
  - 2 gradient: {x[7:3], y[6:1], x[4:0]}, with x and y zero-extended to 8 bits.
  - 3 checker: 8x8 blocks. Pixel = FFFF if (x[3]^y[3]^frame_cnt[0]) else 0000.
- frame_cnt wraps to 0 with no flag.

Test Plan:
- Reset release with enable=1, pattern 0, defaults: frame_start at the 1st tick; vsync high 1392 ticks (3x464); first href rise 9280 ticks after the vsync rise (20 lines x 464); href high 320 ticks, low 144 ticks; 120 href pulses; frame_done 69600 ticks after frame_start; frame_cnt=1.
- Colour-bar byte check on line 0: bytes 0-1 = FF,FF; bytes 40-41 = FF,E0; bytes 200-201 = F8,00; bytes 318-319 = 00,00. Every data change occurs only at a pclk fall.
- pattern 1, solid_rgb565=0x1234; change solid_rgb565 to 0xABCD mid-frame -> every active byte pair in the current frame is 12,34; the next frame is AB,CD.
- Drop enable at line 50 of frame 2 -> frame 2 completes; frame_done fires; frame_cnt=2; FSM returns to IDLE with busy=0 and outputs 0; no further vsync.
- pattern 3 over two consecutive frames -> pixel (0,0) is 0000 in the frame started with frame_cnt=0 and FFFF in the next; pixel (8,0) is FFFF in the first frame.
- Assert reset at line 60 -> all outputs 0 within the same clk (async). After release: no frame_done, frame_cnt=0, and a fresh frame_start at the 1st tick.
